// File: rtl/mem_bus_arbiter_pkg.sv
// rtl/mem_bus_arbiter_pkg.sv - shared types and constants for the IF/MEM SRAM arbiter
package mem_bus_arbiter_pkg;

    // Polarity of the SRAM chip enable
    localparam logic CHIP_ENABLE  = 1'b1;
    localparam logic CHIP_DISABLE = 1'b0;

    // Level of rst that holds the block in reset
    localparam logic RST_ENABLE   = 1'b1;

    // Width of the wait-state down-counter; bounds WAIT_CYCLES to 0..15
    localparam int   WAIT_CNT_W   = 4;
    localparam int   WAIT_MAX     = (1 << WAIT_CNT_W) - 1;

    typedef enum logic [1:0] {
        ARB_IDLE   = 2'd0,
        ARB_ACCESS = 2'd1,
        ARB_RESP   = 2'd2
    } mem_arb_state_t;

    typedef enum logic [1:0] {
        GNT_NONE = 2'd0,
        GNT_IF   = 2'd1,
        GNT_MEM  = 2'd2
    } arb_grant_t;

    // Fixed-priority choice: the load/store port always beats the fetch port
    function automatic arb_grant_t fixed_grant(input logic if_req, input logic mem_req);
        if (mem_req) begin
            return GNT_MEM;
        end
        if (if_req) begin
            return GNT_IF;
        end
        return GNT_NONE;
    endfunction

    // Alternating choice on a tie: hand the SRAM to whichever port did not have it last
    function automatic arb_grant_t rr_grant(input logic if_req, input logic mem_req,
                                            input arb_grant_t last_grant);
        if (if_req && mem_req) begin
            return (last_grant == GNT_MEM) ? GNT_IF : GNT_MEM;
        end
        return fixed_grant(if_req, mem_req);
    endfunction

endpackage

// File: rtl/mem_bus_arbiter.sv
// rtl/mem_bus_arbiter.sv - single-port SRAM arbiter for IF fetch and MEM load/store (option: MEM_ARB_ROUND_ROBIN_EN)
module mem_bus_arbiter
    import mem_bus_arbiter_pkg::*;
#(
    parameter int ADDR_W      = 32,
    parameter int DATA_W      = 32,
    parameter int WAIT_CYCLES = 1
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                if_req,
    input  logic [ADDR_W-1:0]   if_addr,
    output logic                if_ack,
    output logic [DATA_W-1:0]   if_rdata,
    input  logic                mem_req,
    input  logic                mem_we,
    input  logic [ADDR_W-1:0]   mem_addr,
    input  logic [DATA_W/8-1:0] mem_sel,
    input  logic [DATA_W-1:0]   mem_wdata,
    output logic                mem_ack,
    output logic [DATA_W-1:0]   mem_rdata,
    output logic                stallreq_if,
    output logic                stallreq_mem,
    output logic                sram_ce,
    output logic                sram_we,
    output logic [ADDR_W-1:0]   sram_addr,
    output logic [DATA_W/8-1:0] sram_sel,
    output logic [DATA_W-1:0]   sram_wdata,
    input  logic [DATA_W-1:0]   sram_rdata
);

    localparam int                    SEL_W     = DATA_W / 8;
    localparam logic [WAIT_CNT_W-1:0] WAIT_LOAD = WAIT_CNT_W'(WAIT_CYCLES);

    // The wait counter is only 4 bits wide; larger settings cannot be sequenced
    if (WAIT_CYCLES < 0 || WAIT_CYCLES > WAIT_MAX) begin : g_bad_wait_cycles
        $error("mem_bus_arbiter: WAIT_CYCLES must be in 0..15");
    end

    mem_arb_state_t          state;
    mem_arb_state_t          state_nxt;
    arb_grant_t              grant_q;
    arb_grant_t              grant_sel;
    logic [WAIT_CNT_W-1:0]   wait_cnt;
    logic                    wait_done;
    logic                    if_ack_q;
    logic                    mem_ack_q;
    logic [DATA_W-1:0]       if_rdata_q;
    logic [DATA_W-1:0]       mem_rdata_q;
    logic                    sram_ce_q;
    logic                    sram_we_q;
    logic [ADDR_W-1:0]       sram_addr_q;
    logic [SEL_W-1:0]        sram_sel_q;
    logic [DATA_W-1:0]       sram_wdata_q;

    assign wait_done = (wait_cnt == '0);

`ifdef MEM_ARB_ROUND_ROBIN_EN
    arb_grant_t last_grant;

    // Remember who was served last so a tie goes to the other port next time
    always_ff @(posedge clk or posedge rst) begin
        if (rst == RST_ENABLE) begin
            last_grant <= GNT_IF;
        end else if (state == ARB_IDLE && grant_sel != GNT_NONE) begin
            last_grant <= grant_sel;
        end
    end

    // Tie-break by alternation, otherwise serve whoever is asking
    always_comb begin
        grant_sel = rr_grant(if_req, mem_req, last_grant);
    end
`else
    // Mem port always wins; a busy MEM stage can starve fetches
    always_comb begin
        grant_sel = fixed_grant(if_req, mem_req);
    end
`endif

    // State register; reset drops straight back to idle even mid-access
    always_ff @(posedge clk or posedge rst) begin
        if (rst == RST_ENABLE) begin
            state <= ARB_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Next-state: one grant per IDLE visit, WAIT_CYCLES+1 access cycles, one response cycle
    always_comb begin
        state_nxt = state;
        case (state)
            ARB_IDLE: begin
                if (grant_sel != GNT_NONE) begin
                    state_nxt = ARB_ACCESS;
                end
            end
            ARB_ACCESS: begin
                if (wait_done) begin
                    state_nxt = ARB_RESP;
                end
            end
            ARB_RESP: begin
                state_nxt = ARB_IDLE;
            end
            default: begin
                state_nxt = ARB_IDLE;
            end
        endcase
    end

    // Access datapath: latch the winner's request, count wait states, capture read data and pulse ack
    always_ff @(posedge clk or posedge rst) begin
        if (rst == RST_ENABLE) begin
            grant_q      <= GNT_NONE;
            wait_cnt     <= '0;
            if_ack_q     <= 1'b0;
            mem_ack_q    <= 1'b0;
            if_rdata_q   <= '0;
            mem_rdata_q  <= '0;
            sram_ce_q    <= CHIP_DISABLE;
            sram_we_q    <= 1'b0;
            sram_addr_q  <= '0;
            sram_sel_q   <= '0;
            sram_wdata_q <= '0;
        end else begin
            if_ack_q  <= 1'b0;
            mem_ack_q <= 1'b0;
            case (state)
                ARB_IDLE: begin
                    if (grant_sel != GNT_NONE) begin
                        grant_q   <= grant_sel;
                        wait_cnt  <= WAIT_LOAD;
                        sram_ce_q <= CHIP_ENABLE;
                        if (grant_sel == GNT_MEM) begin
                            sram_we_q    <= mem_we;
                            sram_addr_q  <= mem_addr;
                            sram_sel_q   <= mem_sel;
                            sram_wdata_q <= mem_wdata;
                        end else begin
                            // Fetches are always full-word reads
                            sram_we_q    <= 1'b0;
                            sram_addr_q  <= if_addr;
                            sram_sel_q   <= '1;
                            sram_wdata_q <= '0;
                        end
                    end
                end
                ARB_ACCESS: begin
                    if (wait_done) begin
                        sram_ce_q <= CHIP_DISABLE;
                        sram_we_q <= 1'b0;
                        if (grant_q == GNT_MEM) begin
                            mem_rdata_q <= sram_rdata;
                            mem_ack_q   <= 1'b1;
                        end else begin
                            if_rdata_q  <= sram_rdata;
                            if_ack_q    <= 1'b1;
                        end
                    end else begin
                        wait_cnt <= wait_cnt - 1'b1;
                    end
                end
                ARB_RESP: begin
                    grant_q <= GNT_NONE;
                end
                default: begin
                    grant_q <= GNT_NONE;
                end
            endcase
        end
    end

    assign if_ack       = if_ack_q;
    assign mem_ack      = mem_ack_q;
    assign if_rdata     = if_rdata_q;
    assign mem_rdata    = mem_rdata_q;
    assign sram_ce      = sram_ce_q;
    assign sram_we      = sram_we_q;
    assign sram_addr    = sram_addr_q;
    assign sram_sel     = sram_sel_q;
    assign sram_wdata   = sram_wdata_q;

    // A port stalls for as long as it is asking and has not yet seen its ack
    assign stallreq_if  = if_req && !if_ack_q;
    assign stallreq_mem = mem_req && !mem_ack_q;

    // Only one port can be answered per response cycle
    a_ack_exclusive: assert property (@(posedge clk) disable iff (rst)
        !(if_ack_q && mem_ack_q));

    // Acks are single-cycle pulses
    a_if_ack_pulse: assert property (@(posedge clk) disable iff (rst)
        if_ack_q |=> !if_ack_q);
    a_mem_ack_pulse: assert property (@(posedge clk) disable iff (rst)
        mem_ack_q |=> !mem_ack_q);

    // The chip enable tracks the access window exactly
    a_ce_in_access: assert property (@(posedge clk) disable iff (rst)
        sram_ce_q == (state == ARB_ACCESS));

endmodule

// File: tb/tb_mem_bus_arbiter.sv
// tb/tb_mem_bus_arbiter.sv - self-checking bench for mem_bus_arbiter (two instances: WAIT_CYCLES 1 and 0)
module tb_mem_bus_arbiter;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    int          cyc = 0;

    logic        if_req      [2];
    logic [31:0] if_addr     [2];
    logic        if_ack      [2];
    logic [31:0] if_rdata    [2];
    logic        mem_req     [2];
    logic        mem_we      [2];
    logic [31:0] mem_addr    [2];
    logic [3:0]  mem_sel     [2];
    logic [31:0] mem_wdata   [2];
    logic        mem_ack     [2];
    logic [31:0] mem_rdata   [2];
    logic        stallreq_if [2];
    logic        stallreq_mem[2];
    logic        sram_ce     [2];
    logic        sram_we     [2];
    logic [31:0] sram_addr   [2];
    logic [3:0]  sram_sel    [2];
    logic [31:0] sram_wdata  [2];
    logic [31:0] sram_rdata  [2];

    logic [31:0] sram [2][256];
    bit          seeded = 1'b0;

    int pass_cnt  = 0;
    int total_cnt = 0;

    // Model state: one outstanding access per instance, described by the cycle it was granted
    int          wc[2] = '{1, 0};
    int          m_start[2];
    int          m_port[2];
    bit          m_we[2];
    logic [31:0] m_addr[2];
    logic [3:0]  m_sel[2];
    logic [31:0] m_wdata[2];
    logic [31:0] m_if_rd[2];
    logic [31:0] m_mem_rd[2];
    bit          m_mem_known[2];
    int          m_last[2];
    logic [31:0] refm [2][256];
    bit          m_init = 1'b0;

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    mem_bus_arbiter #(.ADDR_W(32), .DATA_W(32), .WAIT_CYCLES(1)) u_dut_w1 (
        .clk(clk), .rst(rst),
        .if_req(if_req[0]), .if_addr(if_addr[0]), .if_ack(if_ack[0]), .if_rdata(if_rdata[0]),
        .mem_req(mem_req[0]), .mem_we(mem_we[0]), .mem_addr(mem_addr[0]), .mem_sel(mem_sel[0]),
        .mem_wdata(mem_wdata[0]), .mem_ack(mem_ack[0]), .mem_rdata(mem_rdata[0]),
        .stallreq_if(stallreq_if[0]), .stallreq_mem(stallreq_mem[0]),
        .sram_ce(sram_ce[0]), .sram_we(sram_we[0]), .sram_addr(sram_addr[0]),
        .sram_sel(sram_sel[0]), .sram_wdata(sram_wdata[0]), .sram_rdata(sram_rdata[0])
    );

    mem_bus_arbiter #(.ADDR_W(32), .DATA_W(32), .WAIT_CYCLES(0)) u_dut_w0 (
        .clk(clk), .rst(rst),
        .if_req(if_req[1]), .if_addr(if_addr[1]), .if_ack(if_ack[1]), .if_rdata(if_rdata[1]),
        .mem_req(mem_req[1]), .mem_we(mem_we[1]), .mem_addr(mem_addr[1]), .mem_sel(mem_sel[1]),
        .mem_wdata(mem_wdata[1]), .mem_ack(mem_ack[1]), .mem_rdata(mem_rdata[1]),
        .stallreq_if(stallreq_if[1]), .stallreq_mem(stallreq_mem[1]),
        .sram_ce(sram_ce[1]), .sram_we(sram_we[1]), .sram_addr(sram_addr[1]),
        .sram_sel(sram_sel[1]), .sram_wdata(sram_wdata[1]), .sram_rdata(sram_rdata[1])
    );

    function automatic logic [31:0] seed_word(input int k, input int i);
        if (k == 0) begin
            if (i == 1) return 32'h2401_0005;
            if (i == 2) return 32'h0BAD_F00D;
            return 32'h0;
        end
        if (i < 16) return 32'hA500_0000 | 32'(i * 32'h111);
        return 32'h0;
    endfunction

    // SRAM models: combinational read, byte-enabled write on every enabled write edge
    assign sram_rdata[0] = sram[0][sram_addr[0][9:2]];
    assign sram_rdata[1] = sram[1][sram_addr[1][9:2]];

    always @(posedge clk) begin
        if (!seeded) begin
            for (int k = 0; k < 2; k++)
                for (int i = 0; i < 256; i++)
                    sram[k][i] <= seed_word(k, i);
            seeded <= 1'b1;
        end else begin
            for (int k = 0; k < 2; k++)
                for (int b = 0; b < 4; b++)
                    if (sram_ce[k] && sram_we[k] && sram_sel[k][b])
                        sram[k][sram_addr[k][9:2]][8*b +: 8] <= sram_wdata[k][8*b +: 8];
        end
    end

    function automatic void chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        total_cnt++;
        if (act === exp) begin
            pass_cnt++;
        end else begin
            $display("FAIL %s @cyc %0d: got 0x%0h expected 0x%0h", nm, cyc, act, exp);
        end
    endfunction

    // Transaction-level model: a grant in an idle cycle t owns the SRAM for cycles t+1..t+W+1
    // and is answered in cycle t+W+2; the next grant can happen in cycle t+W+3.
    task automatic model_step(input int k);
        int   w;
        bit   e_ce, e_resp, e_if_ack, e_mem_ack;
        int   idx;
        int   win;
        w   = wc[k];
        idx = int'(m_addr[k][9:2]);
        if (rst) begin
            m_start[k]     = -1;
            m_if_rd[k]     = '0;
            m_mem_rd[k]    = '0;
            m_mem_known[k] = 1'b1;
            m_last[k]      = 1;
            chk("rst_sram_ce", 32'(sram_ce[k]), 32'd0);
            chk("rst_sram_we", 32'(sram_we[k]), 32'd0);
            chk("rst_if_ack", 32'(if_ack[k]), 32'd0);
            chk("rst_mem_ack", 32'(mem_ack[k]), 32'd0);
            chk("rst_if_rdata", if_rdata[k], 32'd0);
            chk("rst_mem_rdata", mem_rdata[k], 32'd0);
            return;
        end
        e_ce      = (m_start[k] >= 0) && (cyc >= m_start[k] + 1) && (cyc <= m_start[k] + w + 1);
        e_resp    = (m_start[k] >= 0) && (cyc == m_start[k] + w + 2);
        e_if_ack  = e_resp && (m_port[k] == 1);
        e_mem_ack = e_resp && (m_port[k] == 2);
        if (e_if_ack) m_if_rd[k] = refm[k][idx];
        if (e_mem_ack) begin
            if (m_we[k]) begin
                for (int b = 0; b < 4; b++)
                    if (m_sel[k][b]) refm[k][idx][8*b +: 8] = m_wdata[k][8*b +: 8];
                m_mem_known[k] = 1'b0;
            end else begin
                m_mem_rd[k]    = refm[k][idx];
                m_mem_known[k] = 1'b1;
            end
        end
        chk("sram_ce", 32'(sram_ce[k]), 32'(e_ce));
        chk("if_ack", 32'(if_ack[k]), 32'(e_if_ack));
        chk("mem_ack", 32'(mem_ack[k]), 32'(e_mem_ack));
        chk("stallreq_if", 32'(stallreq_if[k]), 32'(if_req[k] && !e_if_ack));
        chk("stallreq_mem", 32'(stallreq_mem[k]), 32'(mem_req[k] && !e_mem_ack));
        chk("if_rdata", if_rdata[k], m_if_rd[k]);
        if (m_mem_known[k]) chk("mem_rdata", mem_rdata[k], m_mem_rd[k]);
        if (e_ce) begin
            chk("sram_we", 32'(sram_we[k]), 32'(m_we[k]));
            chk("sram_addr", sram_addr[k], m_addr[k]);
            chk("sram_sel", 32'(sram_sel[k]), 32'(m_sel[k]));
            if (m_we[k]) chk("sram_wdata", sram_wdata[k], m_wdata[k]);
        end
        if (e_resp) begin
            m_start[k] = -1;
        end else if (m_start[k] < 0 && (if_req[k] || mem_req[k])) begin
            if (if_req[k] && mem_req[k]) begin
`ifdef MEM_ARB_ROUND_ROBIN_EN
                win = (m_last[k] == 2) ? 1 : 2;
`else
                win = 2;
`endif
            end else begin
                win = mem_req[k] ? 2 : 1;
            end
            m_last[k]  = win;
            m_port[k]  = win;
            m_start[k] = cyc;
            if (win == 2) begin
                m_we[k]    = mem_we[k];
                m_addr[k]  = mem_addr[k];
                m_sel[k]   = mem_sel[k];
                m_wdata[k] = mem_wdata[k];
            end else begin
                m_we[k]    = 1'b0;
                m_addr[k]  = if_addr[k];
                m_sel[k]   = 4'hF;
                m_wdata[k] = '0;
            end
        end
    endtask

    // Compare process: every cycle, both instances, against the model
    always @(negedge clk) begin
        if (!m_init) begin
            for (int k = 0; k < 2; k++)
                for (int i = 0; i < 256; i++)
                    refm[k][i] = seed_word(k, i);
            m_init = 1'b1;
        end
        model_step(0);
        model_step(1);
    end

    // Runs one or two overlapping requests on an instance and reports ack cycles relative to t0
    task automatic watch(input int k, input int t0, input bit need_if, input bit need_mem,
                         input bit drop_if_early, input bit raise_mem,
                         output int if_at, output int mem_at, output int stall_cnt, output int we_cnt);
        if_at = -1; mem_at = -1; stall_cnt = 0; we_cnt = 0;
        for (int n = 0; n < 40 && !((!need_if || if_at >= 0) && (!need_mem || mem_at >= 0)); n++) begin
            @(negedge clk);
            if (if_ack[k]) if_at = cyc - t0;
            if (mem_ack[k]) mem_at = cyc - t0;
            if (stallreq_if[k]) stall_cnt++;
            if (sram_ce[k] && sram_we[k]) we_cnt++;
            @(posedge clk); #1;
            if (if_at >= 0 || (drop_if_early && cyc == t0 + 1)) if_req[k] = 1'b0;
            if (mem_at >= 0) mem_req[k] = 1'b0;
            if (raise_mem && mem_at < 0 && cyc == t0 + 1) mem_req[k] = 1'b1;
        end
    endtask

    task automatic set_mem(input int k, input bit we, input logic [31:0] a,
                           input logic [3:0] s, input logic [31:0] d);
        mem_we[k] = we; mem_addr[k] = a; mem_sel[k] = s; mem_wdata[k] = d;
    endtask

    initial begin
        #2000000;
        $display("FAIL global_timeout: got no finish expected finish");
        $fatal(1, "timeout");
    end

    initial begin
        int t0, ia, ma, sc, wcnt, got, prev;
        bit acked;
        for (int k = 0; k < 2; k++) begin
            if_req[k] = 0; if_addr[k] = 0; mem_req[k] = 0;
            set_mem(k, 0, 0, 0, 0);
        end
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("reset_ce", 32'(sram_ce[0]), 32'd0);
        chk("reset_if_rdata", if_rdata[0], 32'd0);
        @(posedge clk); #1;
        rst = 1'b0;
        @(posedge clk); #1;

        // Single fetch, WAIT_CYCLES=1
        if_addr[0] = 32'h0000_0004; if_req[0] = 1'b1; t0 = cyc;
        watch(0, t0, 1, 0, 0, 0, ia, ma, sc, wcnt);
        chk("t1_if_ack_cycle", 32'(ia), 32'd3);
        chk("t1_if_rdata", if_rdata[0], 32'h2401_0005);
        chk("t1_stall_cycles", 32'(sc), 32'd3);

        // Partial store followed by a load of the same word
        set_mem(0, 1, 32'h10, 4'b0011, 32'hDEAD_BEEF); mem_req[0] = 1'b1; t0 = cyc;
        watch(0, t0, 0, 1, 0, 0, ia, ma, sc, wcnt);
        chk("t2_store_ack_cycle", 32'(ma), 32'd3);
        chk("t2_we_cycles", 32'(wcnt), 32'd2);
        set_mem(0, 0, 32'h10, 4'hF, 32'h0); mem_req[0] = 1'b1; t0 = cyc;
        watch(0, t0, 0, 1, 0, 0, ia, ma, sc, wcnt);
        chk("t2_load_ack_cycle", 32'(ma), 32'd3);
        chk("t2_load_data", mem_rdata[0], 32'h0000_BEEF);

        // Tie after a fresh reset: mem first, IF after one idle cycle
        rst = 1'b1; @(posedge clk); #1; rst = 1'b0; @(posedge clk); #1;
        if_addr[0] = 32'h4; set_mem(0, 0, 32'h10, 4'hF, 0);
        if_req[0] = 1'b1; mem_req[0] = 1'b1; t0 = cyc;
        watch(0, t0, 1, 1, 0, 0, ia, ma, sc, wcnt);
        chk("t3_mem_ack_cycle", 32'(ma), 32'd3);
        chk("t3_if_ack_cycle", 32'(ia), 32'd7);
        chk("t3_if_data", if_rdata[0], 32'h2401_0005);
`ifdef MEM_ARB_ROUND_ROBIN_EN
        mem_req[0] = 1'b1; t0 = cyc;
        watch(0, t0, 0, 1, 0, 0, ia, ma, sc, wcnt);
        if_req[0] = 1'b1; mem_req[0] = 1'b1; t0 = cyc;
        watch(0, t0, 1, 1, 0, 0, ia, ma, sc, wcnt);
        chk("t3rr_if_ack_cycle", 32'(ia), 32'd3);
        chk("t3rr_mem_ack_cycle", 32'(ma), 32'd7);
`endif

        // Reset in the first access cycle of a store
        set_mem(0, 1, 32'h20, 4'hF, 32'h1122_3344); mem_req[0] = 1'b1; t0 = cyc;
        @(posedge clk); #1;
        chk("t4_ce_before_rst", 32'(sram_ce[0]), 32'd1);
        rst = 1'b1; #1;
        chk("t4_ce_at_rst", 32'(sram_ce[0]), 32'd0);
        mem_req[0] = 1'b0;
        @(posedge clk); #1; rst = 1'b0;
        got = 0;
        repeat (4) begin
            @(negedge clk);
            if (mem_ack[0]) got++;
        end
        chk("t4_no_ack_after_rst", 32'(got), 32'd0);
        @(posedge clk); #1;
        mem_req[0] = 1'b1; t0 = cyc;
        watch(0, t0, 0, 1, 0, 0, ia, ma, sc, wcnt);
        chk("t4_reissue_ack_cycle", 32'(ma), 32'd3);
        set_mem(0, 0, 32'h20, 4'hF, 0); mem_req[0] = 1'b1; t0 = cyc;
        watch(0, t0, 0, 1, 0, 0, ia, ma, sc, wcnt);
        chk("t4_readback", mem_rdata[0], 32'h1122_3344);

        // Ten back-to-back fetches with no wait states
        if_addr[1] = 32'h0; if_req[1] = 1'b1; t0 = cyc; got = 0; prev = 0;
        for (int j = 0; j < 60 && got < 10; j++) begin
            @(negedge clk);
            acked = if_ack[1];
            if (acked) begin
                chk("t5_data", if_rdata[1], seed_word(1, got));
                if (got == 0) chk("t5_first_latency", 32'(cyc - t0), 32'd2);
                else          chk("t5_spacing", 32'(cyc - prev), 32'd3);
                prev = cyc;
                got++;
            end
            @(posedge clk); #1;
            if (acked) begin
                if (got < 10) if_addr[1] = 32'(got * 4);
                else          if_req[1] = 1'b0;
            end
        end
        chk("t5_ack_count", 32'(got), 32'd10);
        if_req[1] = 1'b0;

        // IF request dropped after one cycle, mem request raised meanwhile
        if_addr[0] = 32'h8; if_req[0] = 1'b1; set_mem(0, 0, 32'h20, 4'hF, 0); t0 = cyc;
        watch(0, t0, 1, 1, 1, 1, ia, ma, sc, wcnt);
        chk("t6_if_ack_cycle", 32'(ia), 32'd3);
        chk("t6_if_data", if_rdata[0], 32'h0BAD_F00D);
        chk("t6_mem_ack_cycle", 32'(ma), 32'd7);
        chk("t6_mem_data", mem_rdata[0], 32'h1122_3344);

        repeat (3) @(posedge clk);
        @(negedge clk);
        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

endmodule
